// File: rtl/cpu_mem_ctrl_pkg.sv
// cpu_defs: shared MEM-stage types (memory op encoding, sequencer state) and
// lane helpers used by the load/store controller.
package cpu_defs;

    typedef logic [4:0]  RegAddr_t;
    typedef logic [31:0] Word_t;

    typedef enum logic [3:0] {
        NONE = 4'd0,
        LB   = 4'd1,
        LBU  = 4'd2,
        LH   = 4'd3,
        LHU  = 4'd4,
        LW   = 4'd5,
        SB   = 4'd6,
        SH   = 4'd7,
        SW   = 4'd8
    } MemOp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } MemCtrlState_t;

    localparam logic [3:0] BE_ALL = 4'b1111;

    function automatic logic is_load(input MemOp_t op);
        return op inside {LB, LBU, LH, LHU, LW};
    endfunction

    function automatic logic is_store(input MemOp_t op);
        return op inside {SB, SH, SW};
    endfunction

    function automatic logic [3:0] lane_be(input MemOp_t op, input logic [1:0] a);
        case (op)
            LB, LBU, SB: lane_be = 4'b0001 << a;
            LH, LHU, SH: lane_be = a[1] ? 4'b1100 : 4'b0011;
            default:     lane_be = BE_ALL;
        endcase
    endfunction

    // Store data is replicated across every lane so the slave can pick any enabled byte.
    function automatic Word_t lane_wdata(input MemOp_t op, input Word_t d);
        case (op)
            SB:      lane_wdata = {4{d[7:0]}};
            SH:      lane_wdata = {2{d[15:0]}};
            default: lane_wdata = d;
        endcase
    endfunction

    function automatic logic misaligned(input MemOp_t op, input logic [1:0] a);
        case (op)
            LH, LHU, SH: misaligned = a[0];
            LW, SW:      misaligned = (a != 2'b00);
            default:     misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_mem_load_ext.sv
// cpu_mem_load_ext: picks the addressed byte/halfword out of a bus read word and
// sign- or zero-extends it to a full register word.
module cpu_mem_load_ext
    import cpu_defs::*;
(
    input  MemOp_t      op,
    input  logic [1:0]  addr_lo,
    input  Word_t       rdata,
    output Word_t       data
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = lane[addr_lo];
    assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        case (op)
            LB:      data = {{24{byte_sel[7]}}, byte_sel};
            LBU:     data = {24'h000000, byte_sel};
            LH:      data = {{16{half_sel[15]}}, half_sel};
            LHU:     data = {16'h0000, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/cpu_mem_ctrl.sv
// cpu_mem_ctrl: MEM-stage load/store sequencer (IDLE->WAIT->DONE) owning the data bus.
// Define CPU_MEM_ALIGN_CHECK_EN to trap misaligned accesses via adel_o/ades_o/badvaddr_o.
module cpu_mem_ctrl
    import cpu_defs::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  RegAddr_t    waddr_i,
    input  Word_t       wdata_i,
    input  MemOp_t      mem_op_i,
    input  logic [31:0] mem_addr_i,
    output logic        we_o,
    output RegAddr_t    waddr_o,
    output Word_t       wdata_o,
    output logic        stall_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_addr_o,
    output Word_t       bus_wdata_o,
    input  logic        bus_ack_i,
    input  Word_t       bus_rdata_i,
    output logic        bus_err_o
`ifdef CPU_MEM_ALIGN_CHECK_EN
    ,
    output logic        adel_o,
    output logic        ades_o,
    output logic [31:0] badvaddr_o
`endif
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    MemCtrlState_t state_reg;
    MemOp_t        op_reg;
    logic [1:0]    alo_reg;
    RegAddr_t      waddr_reg;
    logic [CW-1:0] cnt_reg;
    logic          res_we_reg;
    Word_t         res_wdata_reg;
    logic          bus_req_reg;
    logic          bus_we_reg;
    logic [3:0]    bus_be_reg;
    logic [31:0]   bus_addr_reg;
    Word_t         bus_wdata_reg;
    logic          bus_err_reg;

    Word_t         load_data;
    logic          is_mem;
    logic          align_fault;
    logic          start;

    cpu_mem_load_ext u_load_ext (
        .op      (op_reg),
        .addr_lo (alo_reg),
        .rdata   (bus_rdata_i),
        .data    (load_data)
    );

    assign is_mem = (mem_op_i != NONE);

`ifdef CPU_MEM_ALIGN_CHECK_EN
    // A misaligned access never reaches the bus; the exception is raised in the issue cycle.
    assign align_fault = is_mem && (state_reg == IDLE) && !rst
                         && misaligned(mem_op_i, mem_addr_i[1:0]);
    assign adel_o      = align_fault && is_load(mem_op_i);
    assign ades_o      = align_fault && is_store(mem_op_i);
    assign badvaddr_o  = align_fault ? mem_addr_i : 32'h0;
`else
    assign align_fault = 1'b0;
`endif

    assign start = is_mem && !align_fault;

    assign bus_req_o   = bus_req_reg;
    assign bus_we_o    = bus_we_reg;
    assign bus_be_o    = bus_be_reg;
    assign bus_addr_o  = bus_addr_reg;
    assign bus_wdata_o = bus_wdata_reg;
    assign bus_err_o   = bus_err_reg;

    // Writeback/stall mux: pass-through when idle, latched result in DONE, quiet otherwise.
    always_comb begin
        we_o    = 1'b0;
        waddr_o = '0;
        wdata_o = '0;
        stall_o = 1'b0;
        if (!rst) begin
            case (state_reg)
                IDLE: begin
                    if (!is_mem) begin
                        we_o    = we_i;
                        waddr_o = waddr_i;
                        wdata_o = wdata_i;
                    end else begin
                        stall_o = start;
                    end
                end
                WAIT: stall_o = 1'b1;
                DONE: begin
                    we_o    = res_we_reg;
                    waddr_o = waddr_reg;
                    wdata_o = res_wdata_reg;
                end
                default: stall_o = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            op_reg        <= NONE;
            alo_reg       <= 2'b00;
            waddr_reg     <= '0;
            cnt_reg       <= '0;
            res_we_reg    <= 1'b0;
            res_wdata_reg <= '0;
            bus_req_reg   <= 1'b0;
            bus_we_reg    <= 1'b0;
            bus_be_reg    <= 4'b0000;
            bus_addr_reg  <= '0;
            bus_wdata_reg <= '0;
            bus_err_reg   <= 1'b0;
        end else begin
            bus_err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        op_reg        <= mem_op_i;
                        alo_reg       <= mem_addr_i[1:0];
                        waddr_reg     <= waddr_i;
                        cnt_reg       <= '0;
                        bus_req_reg   <= 1'b1;
                        bus_we_reg    <= is_store(mem_op_i);
                        bus_be_reg    <= lane_be(mem_op_i, mem_addr_i[1:0]);
                        bus_addr_reg  <= {mem_addr_i[31:2], 2'b00};
                        bus_wdata_reg <= lane_wdata(mem_op_i, wdata_i);
                        state_reg     <= WAIT;
                    end
                end
                WAIT: begin
                    cnt_reg <= cnt_reg + CW'(1);
                    // Ack is checked first so an ack on the final cycle still completes normally.
                    if (bus_ack_i || cnt_reg == CNT_LAST) begin
                        res_we_reg    <= bus_ack_i && is_load(op_reg);
                        res_wdata_reg <= load_data;
                        bus_err_reg   <= !bus_ack_i;
                        bus_req_reg   <= 1'b0;
                        bus_we_reg    <= 1'b0;
                        bus_be_reg    <= 4'b0000;
                        bus_addr_reg  <= '0;
                        bus_wdata_reg <= '0;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    res_we_reg <= 1'b0;
                    state_reg  <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mem_ctrl.sv
// tb_cpu_mem_ctrl: table vectors, hand sequences and random transactions for cpu_mem_ctrl,
// checked against a word-arithmetic reference model.
module tb_cpu_mem_ctrl;
    import cpu_defs::*;

    localparam int TMO = 4;

    logic        clk;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    MemOp_t      mem_op_i;
    logic [31:0] mem_addr_i;
    logic        we_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;
    logic        stall_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic        bus_err_o;
`ifdef CPU_MEM_ALIGN_CHECK_EN
    logic        adel_o;
    logic        ades_o;
    logic [31:0] badvaddr_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    cpu_mem_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .we_i        (we_i),
        .waddr_i     (waddr_i),
        .wdata_i     (wdata_i),
        .mem_op_i    (mem_op_i),
        .mem_addr_i  (mem_addr_i),
        .we_o        (we_o),
        .waddr_o     (waddr_o),
        .wdata_o     (wdata_o),
        .stall_o     (stall_o),
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_be_o    (bus_be_o),
        .bus_addr_o  (bus_addr_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_ack_i   (bus_ack_i),
        .bus_rdata_i (bus_rdata_i),
        .bus_err_o   (bus_err_o)
`ifdef CPU_MEM_ALIGN_CHECK_EN
        ,
        .adel_o      (adel_o),
        .ades_o      (ades_o),
        .badvaddr_o  (badvaddr_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        MemOp_t      op;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        int          ack_wait;
        logic [31:0] baddr;
        logic [3:0]  be;
        logic [31:0] bwd;
        logic        we;
        logic [31:0] res;
        logic        err;
    } vec_t;

    // Reference model: lane selection by plain shifts/modulo on the byte address.
    function automatic void model(input MemOp_t op, input logic [31:0] addr, input logic [31:0] wd,
                                  input logic [31:0] rdata, input int ack_wait, output vec_t v);
        int unsigned sh;
        logic [31:0] b;
        logic [31:0] h;
        sh = addr % 4;
        b = (rdata >> (8 * sh)) & 32'hFF;
        h = (rdata >> (16 * (sh / 2))) & 32'hFFFF;
        v.op = op; v.addr = addr; v.wd = wd; v.rdata = rdata; v.ack_wait = ack_wait;
        v.baddr = addr - sh;
        v.err = (ack_wait >= TMO);
        v.be = 4'hF; v.bwd = wd; v.res = rdata;
        case (op)
            LB:  v.res = (b >= 128) ? b - 32'd256 : b;
            LBU: v.res = b;
            LH:  v.res = (h >= 32768) ? h - 32'd65536 : h;
            LHU: v.res = h;
            SB:  begin v.be = 4'(1 << sh); v.bwd = (wd & 32'hFF) * 32'h0101_0101; end
            SH:  begin v.be = (sh >= 2) ? 4'hC : 4'h3; v.bwd = (wd & 32'hFFFF) * 32'h0001_0001; end
            default: ;
        endcase
        v.we = is_load(op) && !v.err;
    endfunction

    // Called and returns at posedge+1 with the controller idle.
    task automatic run_mem(input vec_t v);
        logic st;
        logic [4:0] wa;
        st = is_store(v.op);
        wa = 5'($urandom_range(1, 31));
        $display("txn op=%s addr=%h wd=%h rdata=%h ack_wait=%0d", v.op.name(), v.addr, v.wd, v.rdata, v.ack_wait);
        mem_op_i = v.op; mem_addr_i = v.addr; wdata_i = v.wd; waddr_i = wa;
        we_i = 1'($urandom_range(0, 1)); bus_ack_i = 1'($urandom_range(0, 1)); bus_rdata_i = $urandom;
        #1;
        chk("issue_stall", 32'(stall_o), 32'd1);
        chk("issue_req", 32'(bus_req_o), 32'd0);
        chk("issue_we", 32'(we_o), 32'd0);
        @(posedge clk); #1;
        for (int k = 0; k < TMO; k++) begin
            bus_ack_i = (k == v.ack_wait);
            bus_rdata_i = bus_ack_i ? v.rdata : $urandom;
            chk("wait_req", 32'(bus_req_o), 32'd1);
            chk("wait_stall", 32'(stall_o), 32'd1);
            chk("wait_addr", bus_addr_o, v.baddr);
            chk("wait_bwe", 32'(bus_we_o), 32'(st));
            if (st) begin
                chk("wait_be", 32'(bus_be_o), 32'(v.be));
                chk("wait_bwdata", bus_wdata_o, v.bwd);
            end
            @(posedge clk); #1;
            bus_ack_i = 1'b0;
            if (k == v.ack_wait) break;
        end
        chk("done_stall", 32'(stall_o), 32'd0);
        chk("done_req", 32'(bus_req_o), 32'd0);
        chk("done_err", 32'(bus_err_o), 32'(v.err));
        chk("done_we", 32'(we_o), 32'(v.we));
        if (v.we) begin
            chk("done_waddr", 32'(waddr_o), 32'(wa));
            chk("done_wdata", wdata_o, v.res);
        end
        bus_ack_i = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        mem_op_i = NONE; we_i = 1'b0; bus_ack_i = 1'b0;
        #1;
        chk("after_err", 32'(bus_err_o), 32'd0);
        chk("after_req", 32'(bus_req_o), 32'd0);
        chk("after_stall", 32'(stall_o), 32'd0);
        chk("after_we", 32'(we_o), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic pass_through(input logic we, input logic [4:0] wa, input logic [31:0] wd, input logic ack);
        $display("txn op=NONE we=%0b waddr=%0d wdata=%h ack=%0b", we, wa, wd, ack);
        mem_op_i = NONE; we_i = we; waddr_i = wa; wdata_i = wd; mem_addr_i = $urandom; bus_ack_i = ack;
        #1;
        chk("pt_we", 32'(we_o), 32'(we));
        chk("pt_waddr", 32'(waddr_o), 32'(wa));
        chk("pt_wdata", wdata_o, wd);
        chk("pt_stall", 32'(stall_o), 32'd0);
        chk("pt_req", 32'(bus_req_o), 32'd0);
        @(posedge clk); #1;
        bus_ack_i = 1'b0;
    endtask

    vec_t tbl [8];

    initial begin
        tbl[0] = '{LB,  32'h1003, 32'h0, 32'h80FF_FF00, 2, 32'h1000, 4'h0, 32'h0, 1'b1, 32'hFFFF_FF80, 1'b0};
        tbl[1] = '{LHU, 32'h2002, 32'h0, 32'hBEEF_0000, 0, 32'h2000, 4'h0, 32'h0, 1'b1, 32'h0000_BEEF, 1'b0};
        tbl[2] = '{SH,  32'h2002, 32'h0000_ABCD, 32'h0, 1, 32'h2000, 4'hC, 32'hABCD_ABCD, 1'b0, 32'h0, 1'b0};
        tbl[3] = '{SW,  32'h3000, 32'h1234_5678, 32'h0, 99, 32'h3000, 4'hF, 32'h1234_5678, 1'b0, 32'h0, 1'b1};
`ifdef CPU_MEM_ALIGN_CHECK_EN
        tbl[4] = '{LW,  32'h1000, 32'h0, 32'hCAFE_F00D, 0, 32'h1000, 4'h0, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0};
`else
        tbl[4] = '{LW,  32'h1001, 32'h0, 32'hCAFE_F00D, 0, 32'h1000, 4'h0, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0};
`endif
        tbl[5] = '{LH,  32'h4002, 32'h0, 32'h8001_1234, TMO - 1, 32'h4000, 4'h0, 32'h0, 1'b1, 32'hFFFF_8001, 1'b0};
        tbl[6] = '{SB,  32'h5001, 32'h0000_00A5, 32'h0, 0, 32'h5000, 4'h2, 32'hA5A5_A5A5, 1'b0, 32'h0, 1'b0};
        tbl[7] = '{LBU, 32'h6001, 32'h0, 32'h0000_9C00, 1, 32'h6000, 4'h0, 32'h0, 1'b1, 32'h0000_009C, 1'b0};

        rst = 1'b1; we_i = 1'b0; waddr_i = '0; wdata_i = '0; mem_op_i = NONE;
        mem_addr_i = '0; bus_ack_i = 1'b0; bus_rdata_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", 32'(we_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_req", 32'(bus_req_o), 32'd0);
        chk("rst_err", 32'(bus_err_o), 32'd0);
        chk("rst_addr", bus_addr_o, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        pass_through(1'b1, 5'd5, 32'h0000_1234, 1'b0);
        pass_through(1'b0, 5'd17, 32'hDEAD_BEEF, 1'b1);

        for (int i = 0; i < 8; i++) run_mem(tbl[i]);

        // Reset while a load is waiting: request drops, nothing is written back.
        $display("txn reset-mid-WAIT LW addr=00007000");
        mem_op_i = LW; mem_addr_i = 32'h7000; we_i = 1'b1; waddr_i = 5'd9;
        @(posedge clk); #1;
        chk("mid_req", 32'(bus_req_o), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_req", 32'(bus_req_o), 32'd0);
        chk("mid_rst_stall", 32'(stall_o), 32'd0);
        rst = 1'b0; mem_op_i = NONE; we_i = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'h1111_1111;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mid_no_wb", 32'(we_o), 32'd0);
            chk("mid_no_req", 32'(bus_req_o), 32'd0);
            @(posedge clk); #1;
        end
        bus_ack_i = 1'b0;

`ifdef CPU_MEM_ALIGN_CHECK_EN
        $display("txn align LW addr=00001001");
        mem_op_i = LW; mem_addr_i = 32'h1001; we_i = 1'b1;
        #1;
        chk("al_stall", 32'(stall_o), 32'd0);
        chk("al_we", 32'(we_o), 32'd0);
        chk("al_adel", 32'(adel_o), 32'd1);
        chk("al_ades", 32'(ades_o), 32'd0);
        chk("al_bad", badvaddr_o, 32'h1001);
        @(posedge clk); #1;
        chk("al_req", 32'(bus_req_o), 32'd0);
        $display("txn align SH addr=00002001");
        mem_op_i = SH; mem_addr_i = 32'h2001;
        #1;
        chk("al_ades2", 32'(ades_o), 32'd1);
        chk("al_bad2", badvaddr_o, 32'h2001);
        @(posedge clk); #1;
        chk("al_req2", 32'(bus_req_o), 32'd0);
        mem_op_i = NONE;
        #1;
        chk("al_adel_off", 32'(adel_o), 32'd0);
        @(posedge clk); #1;
`endif

        for (int i = 0; i < 60; i++) begin
            MemOp_t op;
            logic [31:0] addr;
            vec_t v;
            op = MemOp_t'(4'($urandom_range(0, 8)));
            if (op == NONE) begin
                pass_through(1'($urandom_range(0, 1)), 5'($urandom), $urandom, 1'($urandom_range(0, 1)));
            end else begin
                addr = $urandom;
`ifdef CPU_MEM_ALIGN_CHECK_EN
                if (op inside {LH, LHU, SH}) addr = addr - (addr % 2);
                if (op inside {LW, SW}) addr = addr - (addr % 4);
`endif
                model(op, addr, $urandom, $urandom, int'($urandom_range(0, 5)), v);
                run_mem(v);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
